// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and address-advance helper for the
// SRAM-backed AXI3 responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_RESP,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  typedef enum logic {
    CH_READ,
    CH_WRITE
  } chan_t;

  // WRAP is served as INCR; only FIXED holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between the CPU-side master and the SRAM responder.
interface axi_sram_slave_if #(
  parameter int ID_WIDTH = 4
) ();

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one read or write transaction at a time from a
// single-port synchronous SRAM with one cycle of read latency.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int RAM_AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  axi_sram_slave_if.slave   axi,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t              state_q, state_d;
  chan_t               rr_last_q, rr_last_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                first_q, first_d;
  logic                grant_rd, grant_wr, beat_last;

  // Round-robin: on a tie the channel not granted last wins.
  assign grant_rd  = (state_q == S_IDLE) && axi.arvalid &&
                     (!axi.awvalid || rr_last_q == CH_WRITE);
  assign grant_wr  = (state_q == S_IDLE) && axi.awvalid && !grant_rd;
  assign beat_last = (cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    first_d     = 1'b0;
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rid     = '0;
    axi.rlast   = 1'b0;
    axi.rresp   = RESP_OKAY;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = RESP_OKAY;
    ram_en      = 1'b0;
    ram_wen     = 4'b0000;
    ram_addr    = '0;
    ram_wdata   = '0;

    unique case (state_q)
      S_IDLE: begin
        axi.arready = grant_rd;
        axi.awready = grant_wr;
        if (grant_rd) begin
          id_d      = axi.arid;
          addr_d    = axi.araddr;
          len_d     = axi.arlen;
          size_d    = axi.arsize;
          burst_d   = axi.arburst;
          cnt_d     = 8'd0;
          rr_last_d = CH_READ;
          state_d   = S_RD_REQ;
        end else if (grant_wr) begin
          id_d      = axi.awid;
          addr_d    = axi.awaddr;
          len_d     = {4'b0000, axi.awlen};
          size_d    = axi.awsize;
          burst_d   = axi.awburst;
          cnt_d     = 8'd0;
          rr_last_d = CH_WRITE;
          state_d   = S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        ram_en   = 1'b1;
        ram_addr = addr_q[RAM_AW+1:2];
        first_d  = 1'b1;
        state_d  = S_RD_RESP;
      end
      S_RD_RESP: begin
        // SRAM data is only valid in the first cycle; hold it afterwards.
        axi.rvalid = 1'b1;
        axi.rdata  = first_q ? ram_rdata : rdata_q;
        axi.rid    = id_q;
        axi.rlast  = beat_last;
        if (first_q) rdata_d = ram_rdata;
        if (axi.rready) begin
          if (beat_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr(addr_q, size_q, burst_q);
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_DATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          ram_en    = 1'b1;
          ram_wen   = axi.wstrb;
          ram_addr  = addr_q[RAM_AW+1:2];
          ram_wdata = axi.wdata;
          if (beat_last || axi.wlast) begin
            state_d = S_WR_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr(addr_q, size_q, burst_q);
          end
        end
      end
      S_WR_RESP: begin
        axi.bvalid = 1'b1;
        axi.bid    = id_q;
        if (axi.bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_last_q <= CH_WRITE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural 1-cycle SRAM.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:65535];
  logic        pre_we   = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  int errors = 0;
  int checks = 0;

  axi_sram_slave_if #(.ID_WIDTH(4)) bus ();

  axi_sram_slave #(.ID_WIDTH(4), .RAM_AW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .ram_en    (ram_en),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Read data is garbage except in the cycle after a read.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end else begin
      ram_rdata <= 32'hBAD0BAD0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] a,
                        input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = 3'd2;
    bus.arburst = burst; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 20) begin tick(); #1; n++; end
    chk("ar_accept", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && n < 20) begin tick(); #1; n++; end
    chk("aw_accept", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag);
    int n = 0;
    #1;
    while (!bus.rvalid && n < 20) begin tick(); #1; n++; end
    chk(tag, 32'(bus.rvalid), 32'd1);
  endtask

  task automatic rd_beat(input string tag, input logic [31:0] d,
                         input logic last, input logic [3:0] id);
    bus.rready = 1'b1;
    wait_rvalid({tag, "_rvalid"});
    chk({tag, "_rdata"}, bus.rdata, d);
    chk({tag, "_rlast"}, 32'(bus.rlast), 32'(last));
    chk({tag, "_rid"}, 32'(bus.rid), 32'(id));
    chk({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic w_beat(input string tag, input logic [31:0] d, input logic [3:0] strb,
                        input logic last, input logic [15:0] waddr);
    int n = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    #1;
    while (!bus.wready && n < 20) begin tick(); #1; n++; end
    chk({tag, "_wready"}, 32'(bus.wready), 32'd1);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, "_ram_wen"}, 32'(ram_wen), 32'(strb));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(waddr));
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic b_resp(input string tag, input logic [3:0] id);
    int n = 0;
    bus.bready = 1'b1;
    #1;
    while (!bus.bvalid && n < 20) begin tick(); #1; n++; end
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
    chk({tag, "_bid"}, 32'(bus.bid), 32'(id));
    tick();
    bus.bready = 1'b0;
    #1;
    chk({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
  endtask

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
    bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;

    // Reset state and RAM preload
    preload(16'h0000, 32'hDEADBEEF);
    preload(16'h0040, 32'hFFFFFFFF);
    preload(16'h0010, 32'h11111111);
    preload(16'h0011, 32'h22222222);
    preload(16'h0012, 32'h33333333);
    preload(16'h0013, 32'h44444444);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    rst = 1'b0;
    tick();

    // Single read with exact latency: arready T0, ram_en T1, rvalid T2
    bus.rready = 1'b1;
    bus.arid = 4'd3; bus.araddr = 32'h1fc00000; bus.arlen = 8'd0;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    #1;
    chk("t1_arready_T0", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    #1;
    chk("t1_ram_en_T1", 32'(ram_en), 32'd1);
    chk("t1_ram_wen_T1", 32'(ram_wen), 32'd0);
    chk("t1_ram_addr_T1", 32'(ram_addr), 32'h0000);
    chk("t1_arready_busy", 32'(bus.arready), 32'd0);
    tick();
    chk("t1_rvalid_T2", 32'(bus.rvalid), 32'd1);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t1_rlast", 32'(bus.rlast), 32'd1);
    chk("t1_rid", 32'(bus.rid), 32'd3);
    tick();
    bus.rready = 1'b0;
    chk("t1_rvalid_done", 32'(bus.rvalid), 32'd0);

    // Partial-strobe write then read back
    aw_req(4'd5, 32'h00000100, 4'd0, 2'b01);
    w_beat("t2_w", 32'h12345678, 4'b0011, 1'b1, 16'h0040);
    b_resp("t2_b", 4'd5);
    chk("t2_mem", mem[16'h0040], 32'hFFFF5678);
    ar_req(4'd6, 32'h00000100, 8'd0, 2'b01);
    rd_beat("t2_r", 32'hFFFF5678, 1'b1, 4'd6);

    // INCR burst read with rready stalls; data must hold across a stall
    ar_req(4'd7, 32'h00000040, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) begin
      bus.rready = 1'b0;
      wait_rvalid("t3_rvalid");
      chk("t3_rdata", bus.rdata, 32'h11111111 * (b + 1));
      chk("t3_rlast", 32'(bus.rlast), 32'(b == 3));
      tick();
      chk("t3_hold_rvalid", 32'(bus.rvalid), 32'd1);
      chk("t3_hold_rdata", bus.rdata, 32'h11111111 * (b + 1));
      chk("t3_hold_rlast", 32'(bus.rlast), 32'(b == 3));
      chk("t3_no_ram_en", 32'(ram_en), 32'd0);
      bus.rready = 1'b1;
      tick();
    end
    bus.rready = 1'b0;
    chk("t3_done", 32'(bus.rvalid), 32'd0);

    // FIXED burst write: three beats to the same word, one response
    aw_req(4'd2, 32'h00000080, 4'd2, 2'b00);
    w_beat("t4_wA", 32'hAAAA000A, 4'hF, 1'b0, 16'h0020);
    chk("t4_no_bvalid", 32'(bus.bvalid), 32'd0);
    w_beat("t4_wB", 32'hBBBB000B, 4'hF, 1'b0, 16'h0020);
    w_beat("t4_wC", 32'hCCCC000C, 4'hF, 1'b1, 16'h0020);
    b_resp("t4_b", 4'd2);
    chk("t4_mem", mem[16'h0020], 32'hCCCC000C);
    tick();
    chk("t4_single_b", 32'(bus.bvalid), 32'd0);

    // Async reset during beat 2 of a 4-beat read
    ar_req(4'd1, 32'h00000040, 8'd3, 2'b01);
    rd_beat("t6_r0", 32'h11111111, 1'b0, 4'd1);
    wait_rvalid("t6_beat2");
    rst = 1'b1;
    #1;
    chk("t6_rvalid_async", 32'(bus.rvalid), 32'd0);
    chk("t6_ram_en_async", 32'(ram_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_after", 32'(bus.rvalid), 32'd0);
    ar_req(4'd9, 32'h00000048, 8'd0, 2'b01);
    rd_beat("t6_r_new", 32'h33333333, 1'b1, 4'd9);

    // Simultaneous AR/AW right after reset: AR first, then AW
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.arid = 4'd4; bus.araddr = 32'h0; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    bus.awid = 4'd8; bus.awaddr = 32'h200; bus.awlen = 4'd0; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    #1;
    chk("t5_arready_first", 32'(bus.arready), 32'd1);
    chk("t5_awready_first", 32'(bus.awready), 32'd0);
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    rd_beat("t5_r0", 32'hDEADBEEF, 1'b1, 4'd4);
    bus.arid = 4'd4; bus.araddr = 32'h200; bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    #1;
    chk("t5_awready_second", 32'(bus.awready), 32'd1);
    chk("t5_arready_second", 32'(bus.arready), 32'd0);
    tick();
    bus.awvalid = 1'b0;
    #1;
    chk("t5_ar_blocked_wr", 32'(bus.arready), 32'd0);
    w_beat("t5_w", 32'h0BADCAFE, 4'hF, 1'b1, 16'h0080);
    chk("t5_ar_blocked_b", 32'(bus.arready), 32'd0);
    b_resp("t5_b", 4'd8);
    chk("t5_arready_after", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    rd_beat("t5_r1", 32'h0BADCAFE, 1'b1, 4'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder that terminates the CPU-side AXI master (cpu_axi_interface) and serves requests from a single-port synchronous SRAM.
- Used as the memory model in SoC-lite simulation and as the on-chip RAM target in FPGA builds.
- Handles one transaction at a time, read or write, with single-beat or INCR/FIXED bursts. Read and write channels are arbitrated round-robin.

Parameters:
- ID_WIDTH, 4: width of the arid/rid/awid/bid fields.
- RAM_AW, 16: SRAM word-address width. Byte address bits [RAM_AW+1:2] are used; upper bits are ignored, so accesses alias.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- arid  in  ID_WIDTH  read ID.
- araddr  in  32  read byte address.
- arlen  in  8  beats-1; values 0..15 supported.
- arsize  in  3  bytes/beat = 1<<arsize; values 0..2.
- arburst  in  2  00 FIXED, 01 INCR, 10 is treated as INCR.
- arvalid  in  1 / arready  out  1: AR handshake.
- rid  out  ID_WIDTH / rdata  out  32 / rresp  out  2 / rlast  out  1: read response fields.
- rvalid  out  1 / rready  in  1: R handshake.
- awid  in  ID_WIDTH / awaddr  in  32 / awlen  in  4 / awsize  in  3 / awburst  in  2: write address fields, same meaning as AR.
- awvalid  in  1 / awready  out  1: AW handshake.
- wdata  in  32 / wstrb  in  4 / wlast  in  1: write data fields.
- wvalid  in  1 / wready  out  1: W handshake.
- bid  out  ID_WIDTH / bresp  out  2: write response fields.
- bvalid  out  1 / bready  in  1: B handshake.
- ram_en  out  1 / ram_wen  out  4 / ram_addr  out  RAM_AW / ram_wdata  out  32: SRAM request.
- ram_rdata  in  32: SRAM read data, valid the cycle after a read with ram_en=1.

Behaviour:
- Reset (async, rst=1): state IDLE, rr_last=WRITE, all outputs 0. Any transaction in flight is abandoned; no response is ever issued for it.
- rresp and bresp are always 2'b00 (OKAY). rid/bid return the latched arid/awid.
- States: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.
- IDLE arbitration:
  - arready/awready are driven combinationally in IDLE.
  - Only arvalid: arready=1. Only awvalid: awready=1.
  - Both valid: grant the channel not granted last (rr_last), then update rr_last.
  - On handshake, latch id, addr, len, size and burst; clear beat counter cnt.
  - Transitions: IDLE->RD_REQ on AR accept; IDLE->WR_DATA on AW accept. arready/awready=0 outside IDLE.
- RD_REQ (1 cycle): ram_en=1, ram_wen=0, ram_addr=addr_q[RAM_AW+1:2]. Then ->RD_RESP.
- RD_RESP:
  - In the first cycle, capture ram_rdata into rdata_q and assert rvalid.
  - rdata, rid and rlast stay stable until rready.
  - rlast = (cnt==len_q).
  - On handshake: if rlast, ->IDLE; else cnt++, advance the address, ->RD_REQ.
  - Best-case throughput is 1 beat per 2 cycles.
- WR_DATA:
  - wready=1.
  - On wvalid: ram_en=1, ram_wen=wstrb, ram_addr from addr_q, ram_wdata=wdata.
  - Beat is last if (cnt==len_q) or wlast. Last beat ->WR_RESP; otherwise cnt++ and advance the address.
  - wstrb=0 still asserts ram_en with ram_wen=0 (harmless read).
  - W beats arriving before AW acceptance wait, because wready=0 outside WR_DATA.
- WR_RESP: bvalid=1 until bready, then ->IDLE. No new AR/AW is accepted until then.
- Address advance:
  - INCR: addr += (1<<size); the 32-bit add wraps silently.
  - FIXED: address is unchanged.
  - Narrow reads return the full SRAM word; byte lane selection is the master's job.
- ram_en=0 in every cycle not listed above. ram_wen=0 whenever ram_en=0.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings BURST_FIXED/INCR/WRAP.
  - RESP_OKAY.
  - State enum values.
  - Helper function next_addr(addr, size, burst).
- No sub-module; a single FSM module. The SRAM itself is external; the bench uses a behavioural 1-cycle-latency RAM.

Test Plan:
- Single read: preload word 0x1fc00000 alias = 0xDEADBEEF; AR addr 0x1fc00000, len 0, id 3, rready=1 -> arready at T0, ram_en at T1, rvalid with rdata=0xDEADBEEF, rlast=1, rid=3 at T2.
- Write then read: AW 0x100, len 0, W 0x12345678, wstrb 4'b0011 over RAM preset 0xFFFFFFFF -> bvalid with bresp 00; subsequent read of 0x100 returns 0xFFFF5678.
- INCR burst read: arlen 3, size 2, addr 0x40, rready toggling 1/0 -> 4 beats from 0x40/44/48/4C. Data is held stable across stalls; rlast only on beat 4.
- FIXED burst write: awlen 2, awburst 00, addr 0x80, data A/B/C -> 3 writes to word 0x20; final content C; single bvalid.
- Simultaneous arvalid+awvalid from reset -> AR granted first (rr_last=WRITE); on the next simultaneous request AW is granted. No beats interleave.
- Reset mid-burst: assert rst during RD_RESP of beat 2 of 4 -> rvalid/ram_en drop to 0 immediately (async); after release a new AR is accepted and served correctly.
